// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction fetch stage for the microcoded controller.
// Owns the PC and fetches words from instruction memory over a req/ack
// handshake. It holds the current instruction while the controller's STY
// bit asks for extra cycles, and resolves the next PC from the BT field
// and the ALU result.
//
// Build option: define MISALIGN_TRAP_EN to redirect misaligned targets to
// TRAP_VECTOR and pulse o_trap. When the macro is not defined, the two low
// bits of every target are cleared and o_trap is tied to 0.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
`ifdef MISALIGN_TRAP_EN
  ,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
`endif
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  i_bt,
  input  logic        i_sty,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_imm,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_ack,
  output logic [31:0] o_instr,
  output logic        o_instr_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_redirect,
  output logic        o_trap
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [2:0] BT_SEQ  = 3'b000;
  localparam logic [2:0] BT_JAL  = 3'b001;
  localparam logic [2:0] BT_JALR = 3'b010;
  localparam logic [2:0] BT_BEQ  = 3'b011;
  localparam logic [2:0] BT_BNE  = 3'b100;
  localparam logic [2:0] BT_BLT  = 3'b101;
  localparam logic [2:0] BT_BGE  = 3'b110;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_req;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_redirect;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_tgt;
  logic [31:0] w_jalr_tgt;
  logic [31:0] w_raw_next;
  logic [31:0] w_next_pc;
  logic        w_misalign;
  logic        w_redirect;

  // The sequential address and the PC-relative target share one adder
  // each; both wrap modulo 2^32 with the carry dropped.
  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_branch_tgt = r_pc + i_imm;
  assign w_jalr_tgt   = {i_alu_result[31:1], 1'b0};

  // Choose the raw next PC from the branch type. The reserved code 111
  // falls through to the sequential case.
  always_comb begin
    w_raw_next = w_pc_plus4;
    case (i_bt)
      BT_SEQ:  w_raw_next = w_pc_plus4;
      BT_JAL:  w_raw_next = w_branch_tgt;
      BT_JALR: w_raw_next = w_jalr_tgt;
      BT_BEQ:  w_raw_next = (i_alu_result == 32'd0) ? w_branch_tgt : w_pc_plus4;
      BT_BNE:  w_raw_next = (i_alu_result != 32'd0) ? w_branch_tgt : w_pc_plus4;
      BT_BLT:  w_raw_next = i_alu_result[0]         ? w_branch_tgt : w_pc_plus4;
      BT_BGE:  w_raw_next = !i_alu_result[0]        ? w_branch_tgt : w_pc_plus4;
      default: w_raw_next = w_pc_plus4;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  // A target that is not word-aligned is replaced by the trap vector.
  // A trap always counts as a redirect, even if the vector happens to
  // equal pc+4.
  assign w_misalign = |w_raw_next[1:0];
  assign w_next_pc  = w_misalign ? TRAP_VECTOR : w_raw_next;
  assign w_redirect = w_misalign || (w_next_pc != w_pc_plus4);
`else
  // Without trapping, the low two bits are cleared so that the PC stays
  // word-aligned.
  assign w_misalign = 1'b0;
  assign w_next_pc  = w_raw_next & ~32'h0000_0003;
  assign w_redirect = (w_next_pc != w_pc_plus4);
`endif

`ifdef MISALIGN_TRAP_EN
  logic r_trap;

  // Trap flag: it pulses in the first fetch cycle after a misaligned exit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_trap <= 1'b0;
    end else begin
      r_trap <= (r_state == S_EXEC) && !i_sty && w_misalign;
    end
  end

  assign o_trap = r_trap;
`else
  assign o_trap = 1'b0;
`endif

  // Fetch/execute FSM. It owns the PC, the instruction latch, the fetch
  // request and the redirect pulse. The request is a register so that it
  // is 0 during reset and rises on the first clock after reset is released.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_FETCH;
      r_req      <= 1'b0;
      r_pc       <= RESET_PC;
      r_instr    <= NOP_INSTR;
      r_redirect <= 1'b0;
    end else begin
      r_redirect <= 1'b0;
      case (r_state)
        S_FETCH: begin
          // An ack counts only while the request is visible on the bus.
          if (r_req && i_imem_ack) begin
            r_instr <= i_imem_rdata;
            r_req   <= 1'b0;
            r_state <= S_EXEC;
          end else begin
            r_req <= 1'b1;
          end
        end
        S_EXEC: begin
          // STY holds the PC and instruction for one more cycle. Any ack
          // seen here is ignored.
          if (!i_sty) begin
            r_pc       <= w_next_pc;
            r_req      <= 1'b1;
            r_redirect <= w_redirect;
            r_state    <= S_FETCH;
          end
        end
      endcase
    end
  end

  assign o_imem_req    = r_req;
  assign o_imem_addr   = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_valid = (r_state == S_EXEC);
  assign o_pc          = r_pc;
  assign o_pc_plus4    = w_pc_plus4;
  assign o_redirect    = r_redirect;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and randomized bench for pc_fetch_unit.
// It keeps its own record of the PC and the current instruction, and
// derives each next PC straight from the branch rules.
module tb_pc_fetch_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] TRAPV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  i_bt;
  logic        i_sty;
  logic [31:0] i_alu_result;
  logic [31:0] i_imm;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_rdata;
  logic        i_imem_ack;
  logic [31:0] o_instr;
  logic        o_instr_valid;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;
  logic        o_redirect;
  logic        o_trap;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_pc;
  logic [31:0] m_instr;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_bt          (i_bt),
    .i_sty         (i_sty),
    .i_alu_result  (i_alu_result),
    .i_imm         (i_imm),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_rdata  (i_imem_rdata),
    .i_imem_ack    (i_imem_ack),
    .o_instr       (o_instr),
    .o_instr_valid (o_instr_valid),
    .o_pc          (o_pc),
    .o_pc_plus4    (o_pc_plus4),
    .o_redirect    (o_redirect),
    .o_trap        (o_trap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference next PC, built from the branch-type rules.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [2:0] bt,
                                           input logic [31:0] alu, input logic [31:0] imm,
                                           output bit tr);
    logic [31:0] t;
    bit          taken;
    case (bt)
      3'd1:    taken = 1'b1;
      3'd3:    taken = (alu == 0);
      3'd4:    taken = (alu != 0);
      3'd5:    taken = alu[0];
      3'd6:    taken = !alu[0];
      default: taken = 1'b0;
    endcase
    t = taken ? pc + imm : pc + 32'd4;
    if (bt == 3'd2) t = alu & 32'hFFFF_FFFE;
    tr = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if ((t % 4) != 0) begin
      tr = 1'b1;
      t  = TRAPV;
    end
`else
    t = t - (t % 4);
`endif
    return t;
  endfunction

  // Fetch phase: the ack is withheld for dly cycles, then the word is returned.
  task automatic fetch(input int dly, input logic [31:0] word);
    for (int k = 0; k < dly; k++) begin
      chk("fetch_req_wait", 32'(o_imem_req), 32'd1);
      chk("fetch_addr_wait", o_imem_addr, m_pc);
      chk("fetch_valid_low", 32'(o_instr_valid), 32'd0);
      @(posedge clk); @(negedge clk);
    end
    chk("fetch_req", 32'(o_imem_req), 32'd1);
    chk("fetch_addr", o_imem_addr, m_pc);
    i_imem_ack   = 1'b1;
    i_imem_rdata = word;
    @(posedge clk); @(negedge clk);
    i_imem_ack   = 1'b0;
    i_imem_rdata = $urandom;
    m_instr      = word;
  endtask

  // Execute phase: nsty hold cycles, then an exit with the given bt.
  // noise drives a stray ack during EXEC.
  task automatic exec(input logic [2:0] bt, input int nsty, input logic [31:0] alu,
                      input logic [31:0] imm, input bit noise);
    logic [31:0] exp;
    bit          tr;
    for (int s = 0; s <= nsty; s++) begin
      chk("exec_valid", 32'(o_instr_valid), 32'd1);
      chk("exec_instr", o_instr, m_instr);
      chk("exec_pc", o_pc, m_pc);
      chk("exec_pc4", o_pc_plus4, m_pc + 32'd4);
      chk("exec_req_low", 32'(o_imem_req), 32'd0);
      i_sty        = (s < nsty);
      i_bt         = i_sty ? 3'($urandom) : bt;
      i_alu_result = alu;
      i_imm        = imm;
      if (noise) begin
        i_imem_ack   = 1'b1;
        i_imem_rdata = ~m_instr;
      end
      @(posedge clk); @(negedge clk);
      i_imem_ack = 1'b0;
    end
    i_sty = 1'b0;
    exp = ref_next(m_pc, bt, alu, imm, tr);
    chk("next_pc", o_pc, exp);
    chk("redirect", 32'(o_redirect), 32'((exp != m_pc + 32'd4) || tr));
    chk("trap", 32'(o_trap), 32'(tr));
    chk("exit_valid_low", 32'(o_instr_valid), 32'd0);
    chk("exit_req", 32'(o_imem_req), 32'd1);
    chk("exit_instr_kept", o_instr, m_instr);
    m_pc = exp;
  endtask

  initial begin
    rstn         = 1'b0;
    i_bt         = 3'd0;
    i_sty        = 1'b0;
    i_alu_result = 32'd0;
    i_imm        = 32'd0;
    i_imem_rdata = 32'd0;
    i_imem_ack   = 1'b0;
    m_pc         = RPC;
    m_instr      = NOP;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(o_imem_req), 32'd0);
    chk("rst_valid", 32'(o_instr_valid), 32'd0);
    chk("rst_redirect", 32'(o_redirect), 32'd0);
    chk("rst_trap", 32'(o_trap), 32'd0);
    chk("rst_pc", o_pc, RPC);
    chk("rst_instr", o_instr, NOP);
    rstn = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("first_req", 32'(o_imem_req), 32'd1);

    // Sequential fetches with immediate ack: addresses 0, 4, 8
    for (int i = 0; i < 3; i++) begin
      chk("t1_addr", o_imem_addr, 32'(4 * i));
      fetch(0, $urandom);
      exec(3'd0, 0, $urandom, $urandom, 1'b0);
    end

    // beq taken / not taken from pc 0x20
    fetch(0, $urandom);
    exec(3'd1, 0, 32'd0, 32'h20 - m_pc, 1'b0);
    fetch(0, $urandom);
    exec(3'd3, 0, 32'd0, 32'h10, 1'b0);
    chk("t2_taken_addr", o_imem_addr, 32'h30);
    chk("t2_taken_redir", 32'(o_redirect), 32'd1);
    fetch(0, $urandom);
    exec(3'd1, 0, 32'd0, 32'hFFFF_FFF0, 1'b0);
    fetch(0, $urandom);
    exec(3'd3, 0, 32'd5, 32'h10, 1'b0);
    chk("t2_nt_addr", o_imem_addr, 32'h24);
    chk("t2_nt_redir", 32'(o_redirect), 32'd0);

    // Load-style hold: two EXEC cycles with a stray ack, then pc+4
    fetch(1, $urandom);
    exec(3'd0, 1, 32'd0, 32'd0, 1'b1);
    chk("t3_addr", o_imem_addr, 32'h28);

    // jalr to a misaligned target
    fetch(0, $urandom);
`ifdef MISALIGN_TRAP_EN
    exec(3'd2, 0, 32'h106, 32'd0, 1'b0);
    chk("t4_trap_pc", o_pc, 32'h100);
    chk("t4_trap", 32'(o_trap), 32'd1);
`else
    exec(3'd2, 0, 32'h105, 32'd0, 1'b0);
    chk("t4_jalr_addr", o_imem_addr, 32'h104);
    chk("t4_trap0", 32'(o_trap), 32'd0);
`endif

    // Delayed ack, then reset during a waiting fetch with a coincident ack
    fetch(5, $urandom);
    exec(3'd0, 0, 32'd0, 32'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("t5_hold_req", 32'(o_imem_req), 32'd1);
      chk("t5_hold_addr", o_imem_addr, m_pc);
      @(posedge clk); @(negedge clk);
    end
    i_imem_ack   = 1'b1;
    i_imem_rdata = 32'hDEAD_BEEF;
    rstn         = 1'b0;
    #1;
    chk("t5_rst_req", 32'(o_imem_req), 32'd0);
    chk("t5_rst_pc", o_pc, RPC);
    @(posedge clk); @(negedge clk);
    chk("t5_rst_instr", o_instr, NOP);
    chk("t5_rst_valid", 32'(o_instr_valid), 32'd0);
    i_imem_ack = 1'b0;
    rstn       = 1'b1;
    m_pc       = RPC;
    m_instr    = NOP;
    @(posedge clk); @(negedge clk);
    chk("t5_restart_addr", o_imem_addr, RPC);

    // PC wraparound from 0xFFFF_FFFC
    fetch(0, $urandom);
    exec(3'd1, 0, 32'd0, 32'hFFFF_FFFC - m_pc, 1'b0);
    chk("t6_top_addr", o_imem_addr, 32'hFFFF_FFFC);
    fetch(0, $urandom);
    exec(3'd0, 0, 32'd0, 32'd0, 1'b0);
    chk("t6_wrap_addr", o_imem_addr, 32'd0);

    // Randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      logic [31:0] alu;
      logic [31:0] imm;
      fetch($urandom_range(0, 3), $urandom);
      alu = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      imm = $urandom;
      if ($urandom_range(0, 7) != 0) imm = imm & 32'hFFFF_FFFC;
      exec(3'($urandom), $urandom_range(0, 2), alu, imm, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
